// File: rtl/udc_pkg.sv
// Shared constants and the BCD-to-7-segment decoder for the up/down display counter.
package udc_pkg;

  localparam logic [3:0] BCD_MAX   = 4'd9;

  // Active-low segments {dp,g,f,e,d,c,b,a}; dp is held off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_updown_display_if.sv
// Board-side bundle: switch/button controls in, count, segments, anodes and LEDs out.
interface bcd_updown_display_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  upDown;
  logic                  en;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     an;
  logic [7:0]            led;

  modport master (
    output upDown, en, load, load_val,
    input  count, wrap, seg, an, led
  );

  modport slave (
    input  upDown, en, load, load_val,
    output count, wrap, seg, an, led
  );
endinterface

// File: rtl/bcd_digit_cell.sv
// One BCD decade: computes its next value and the ripple carry/borrow for the next decade.
module bcd_digit_cell
  import udc_pkg::*;
(
  input  logic       i_up,
  input  logic       i_step_in,
  input  logic       i_load,
  input  logic [3:0] i_ld_val,
  input  logic [3:0] i_cur,
  output logic [3:0] o_nxt_c,
  output logic       o_carry_out_c
);

  always_comb begin
    o_nxt_c       = i_cur;
    o_carry_out_c = 1'b0;
    if (i_load) begin
      // Non-decimal nibbles are sanitised to zero on load
      o_nxt_c = (i_ld_val > BCD_MAX) ? 4'd0 : i_ld_val;
    end else if (i_step_in) begin
      if (i_up) begin
        if (i_cur >= BCD_MAX) begin
          o_nxt_c       = 4'd0;
          o_carry_out_c = 1'b1;
        end else begin
          o_nxt_c = i_cur + 4'd1;
        end
      end else begin
        if (i_cur == 4'd0) begin
          o_nxt_c       = BCD_MAX;
          o_carry_out_c = 1'b1;
        end else begin
          o_nxt_c = i_cur - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_display.sv
// Multi-digit BCD up/down counter with prescaler, multiplexed 7-segment scan and status LEDs.
module bcd_updown_display
  import udc_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 64,
  parameter int unsigned SCAN_DIV = 16,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_updown_display_if.slave  bus
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = (DIGITS   > 1) ? $clog2(DIGITS)   : 1;

  logic [CW-1:0]     r_count;
  logic [PW-1:0]     r_presc;
  logic [SW-1:0]     r_scan;
  logic [DW-1:0]     r_dig;
  logic              r_wrap;
  logic              r_ovf;
  logic [DIGITS-1:0] r_an;
  logic [7:0]        r_seg;
  logic [7:0]        r_led;

  logic [DIGITS:0]   w_chain;
  logic [CW-1:0]     w_count_nxt;
  logic              w_ovf_nxt;
  logic [DIGITS-1:0] w_zero_above;
  logic [3:0]        w_nib;
  logic              w_blank;

  // Load suppresses the step; the cells also give load priority
  assign w_chain[0] = bus.en && (r_presc == '0) && !bus.load;
  assign w_ovf_nxt  = bus.load ? 1'b0 : (r_ovf | w_chain[DIGITS]);

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_digit_cell u_cell (
      .i_up          (bus.upDown),
      .i_step_in     (w_chain[g]),
      .i_load        (bus.load),
      .i_ld_val      (bus.load_val[4*g +: 4]),
      .i_cur         (r_count[4*g +: 4]),
      .o_nxt_c       (w_count_nxt[4*g +: 4]),
      .o_carry_out_c (w_chain[g+1])
    );
    assign w_zero_above[g] = (r_count[CW-1:4*g] == '0);
  end

  assign w_nib   = r_count[4*r_dig +: 4];
  assign w_blank = (BLANK_LZ != 0) && (r_dig != '0) && w_zero_above[r_dig];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_presc <= '0;
      r_wrap  <= 1'b0;
      r_ovf   <= 1'b0;
      r_led   <= '0;
    end else begin
      r_count <= w_count_nxt;
      r_wrap  <= w_chain[DIGITS];
      r_ovf   <= w_ovf_nxt;
      // LEDs follow the next-state so they line up with count
      r_led   <= {w_ovf_nxt, bus.en, bus.upDown, 1'b0, w_count_nxt[3:0]};
      if (bus.load) begin
        r_presc <= '0;
      end else if (bus.en) begin
        r_presc <= (r_presc == PW'(TICK_DIV - 1)) ? '0 : r_presc + PW'(1);
      end
    end
  end

  // Free-running anode scan; an/seg lag dig/count by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan <= '0;
      r_dig  <= '0;
      r_an   <= '1;
      r_seg  <= SEG_BLANK;
    end else begin
      if (r_scan == SW'(SCAN_DIV - 1)) begin
        r_scan <= '0;
        r_dig  <= (r_dig == DW'(DIGITS - 1)) ? '0 : r_dig + DW'(1);
      end else begin
        r_scan <= r_scan + SW'(1);
      end
      r_an  <= ~(DIGITS'(1) << r_dig);
      r_seg <= w_blank ? SEG_BLANK : bcd_to_seg(w_nib);
    end
  end

  assign bus.count = r_count;
  assign bus.wrap  = r_wrap;
  assign bus.seg   = r_seg;
  assign bus.an    = r_an;
  assign bus.led   = r_led;

endmodule
